// File: rtl/w_stage_ctrl_pkg.sv
// Shared MIPS encodings, write-data selectors and load-extract modes for the
// W stage and the later M-stage load/store units.
package mips_defs;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_R   = 6'h00;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_ORI = 6'h0D;
  localparam logic [5:0] OP_LUI = 6'h0F;
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_MFHI = 6'h10;
  localparam logic [5:0] FN_MFLO = 6'h12;
  localparam logic [5:0] FN_MULT = 6'h18;
  localparam logic [5:0] FN_DIV  = 6'h1A;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;

  // Write-data select and forwarding source codes
  localparam logic [2:0] WD_SEL_ALU  = 3'd0;
  localparam logic [2:0] WD_SEL_LOAD = 3'd1;
  localparam logic [2:0] WD_SEL_PC8  = 3'd2;
  localparam logic [2:0] GIVE_NONE   = 3'd7;

  // Load extraction modes
  typedef enum logic [2:0] {
    LX_WORD  = 3'd0,
    LX_BYTE  = 3'd1,
    LX_UBYTE = 3'd2,
    LX_HALF  = 3'd3,
    LX_UHALF = 3'd4
  } lx_mode_e;

endpackage

// File: rtl/w_stage_ctrl_load_ext.sv
// Combinational little-endian load extractor: picks a byte/half/word out of
// the raw memory word and sign- or zero-extends it to DATA_W.
module load_ext
  import mips_defs::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_dm,
  input  logic [1:0]        i_addr_low,
  input  lx_mode_e          i_mode,
  output logic [DATA_W-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Select the addressed byte and halfword (addr_low[0] ignored for halves)
  always_comb begin
    w_byte = 8'h00;
    case (i_addr_low)
      2'd0:    w_byte = i_dm[7:0];
      2'd1:    w_byte = i_dm[15:8];
      2'd2:    w_byte = i_dm[23:16];
      2'd3:    w_byte = i_dm[31:24];
      default: w_byte = 8'h00;
    endcase
    if (i_addr_low[1]) begin
      w_half = i_dm[31:16];
    end else begin
      w_half = i_dm[15:0];
    end
  end

  // Extend the selected field to the full datapath width
  always_comb begin
    o_data = '0;
    case (i_mode)
      LX_WORD:  o_data = DATA_W'($signed(i_dm[31:0]));
      LX_BYTE:  o_data = DATA_W'($signed(w_byte));
      LX_UBYTE: o_data = DATA_W'(w_byte);
      LX_HALF:  o_data = DATA_W'($signed(w_half));
      LX_UHALF: o_data = DATA_W'(w_half);
      default:  o_data = '0;
    endcase
  end

endmodule

// File: rtl/w_stage_ctrl.sv
// Writeback-stage controller: M->W pipeline register with stall/flush/valid,
// register-file write decode, forwarding source code and final write data.
module w_stage_ctrl
  import mips_defs::*;
#(
  parameter int DATA_W    = 32,
  parameter int REG_AW    = 5,
  parameter int LINK_REG  = 31,
  parameter int EXT_LOADS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              flush,
  input  logic [31:0]       instr_M,
  input  logic [DATA_W-1:0] pc_M,
  input  logic [DATA_W-1:0] alu_out_M,
  input  logic [DATA_W-1:0] dm_out_M,
  input  logic [1:0]        addr_low_M,
  output logic              valid_W,
  output logic [31:0]       instr_W,
  output logic [DATA_W-1:0] pc_W,
  output logic              reg_write,
  output logic [REG_AW-1:0] reg_addr,
  output logic [2:0]        reg_data_op,
  output logic [2:0]        give_W_op,
  output logic [DATA_W-1:0] wd_W
);

  logic              r_valid;
  logic [31:0]       r_instr;
  logic [DATA_W-1:0] r_pc;
  logic [DATA_W-1:0] r_alu;
  logic [DATA_W-1:0] r_dm;
  logic [1:0]        r_addr_low;

  logic              w_wr_rd;
  logic              w_wr_rt;
  logic              w_wr_link;
  logic              w_is_load;
  logic              w_is_link;
  lx_mode_e          w_lx_mode;
  logic [REG_AW-1:0] w_dest;
  logic              w_write;
  logic [DATA_W-1:0] w_load_data;
  logic [5:0]        w_op;
  logic [5:0]        w_fn;

  // M->W pipeline register: bubble on flush, capture on en, else hold
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid    <= 1'b0;
      r_instr    <= 32'h0;
      r_pc       <= '0;
      r_alu      <= '0;
      r_dm       <= '0;
      r_addr_low <= 2'd0;
    end else if (flush) begin
      r_valid    <= 1'b0;
      r_instr    <= 32'h0;
      r_pc       <= '0;
      r_alu      <= '0;
      r_dm       <= '0;
      r_addr_low <= 2'd0;
    end else if (en) begin
      r_valid    <= 1'b1;
      r_instr    <= instr_M;
      r_pc       <= pc_M;
      r_alu      <= alu_out_M;
      r_dm       <= dm_out_M;
      r_addr_low <= addr_low_M;
    end else begin
      r_valid    <= r_valid;
      r_instr    <= r_instr;
      r_pc       <= r_pc;
      r_alu      <= r_alu;
      r_dm       <= r_dm;
      r_addr_low <= r_addr_low;
    end
  end

  assign w_op = r_instr[31:26];
  assign w_fn = r_instr[5:0];

  // Decode destination class, load mode and link behaviour from instr_W
  always_comb begin
    w_wr_rd   = 1'b0;
    w_wr_rt   = 1'b0;
    w_wr_link = 1'b0;
    w_is_load = 1'b0;
    w_is_link = 1'b0;
    w_lx_mode = LX_WORD;
    case (w_op)
      OP_R: begin
        case (w_fn)
          FN_ADD, FN_SUB, FN_SLL, FN_MFHI, FN_MFLO: w_wr_rd = 1'b1;
          FN_JALR: begin
            w_wr_rd   = 1'b1;
            w_is_link = 1'b1;
          end
          default: w_wr_rd = 1'b0;
        endcase
      end
      OP_ORI, OP_LUI: w_wr_rt = 1'b1;
      OP_LW: begin
        w_wr_rt   = 1'b1;
        w_is_load = 1'b1;
        w_lx_mode = LX_WORD;
      end
      OP_LB, OP_LBU, OP_LH, OP_LHU: begin
        if (EXT_LOADS != 0) begin
          w_wr_rt   = 1'b1;
          w_is_load = 1'b1;
          case (w_op)
            OP_LB:   w_lx_mode = LX_BYTE;
            OP_LBU:  w_lx_mode = LX_UBYTE;
            OP_LH:   w_lx_mode = LX_HALF;
            OP_LHU:  w_lx_mode = LX_UHALF;
            default: w_lx_mode = LX_WORD;
          endcase
        end else begin
          w_wr_rt   = 1'b0;
          w_is_load = 1'b0;
        end
      end
      OP_JAL: begin
        w_wr_link = 1'b1;
        w_is_link = 1'b1;
      end
      default: w_wr_rt = 1'b0;
    endcase
  end

  // Pick destination register; $0 writes are suppressed entirely
  always_comb begin
    w_dest = '0;
    if (w_wr_link) begin
      w_dest = REG_AW'(LINK_REG);
    end else if (w_wr_rt) begin
      w_dest = REG_AW'(r_instr[20:16]);
    end else if (w_wr_rd) begin
      w_dest = REG_AW'(r_instr[15:11]);
    end else begin
      w_dest = '0;
    end
    w_write = r_valid & (w_wr_rd | w_wr_rt | w_wr_link) & (w_dest != '0);
  end

  load_ext #(.DATA_W(DATA_W)) u_load_ext (
    .i_dm       (r_dm),
    .i_addr_low (r_addr_low),
    .i_mode     (w_lx_mode),
    .o_data     (w_load_data)
  );

  // Write controls, forwarding source and final write data
  always_comb begin
    reg_write   = w_write;
    reg_addr    = '0;
    reg_data_op = WD_SEL_ALU;
    give_W_op   = GIVE_NONE;
    wd_W        = r_alu;
    if (w_is_load) begin
      reg_data_op = WD_SEL_LOAD;
    end else if (w_is_link) begin
      reg_data_op = WD_SEL_PC8;
    end else begin
      reg_data_op = WD_SEL_ALU;
    end
    if (w_write) begin
      reg_addr  = w_dest;
      give_W_op = reg_data_op;
    end else begin
      reg_addr  = '0;
      give_W_op = GIVE_NONE;
    end
    case (reg_data_op)
      WD_SEL_LOAD: wd_W = w_load_data;
      WD_SEL_PC8:  wd_W = r_pc + DATA_W'(8);
      default:     wd_W = r_alu;
    endcase
  end

  assign valid_W = r_valid;
  assign instr_W = r_instr;
  assign pc_W    = r_pc;

endmodule

// File: tb/tb_w_stage_ctrl.sv
// Directed bench for w_stage_ctrl with hand-computed expected values.
module tb_w_stage_ctrl;

  logic        clk;
  logic        reset;
  logic        en;
  logic        flush;
  logic [31:0] instr_M;
  logic [31:0] pc_M;
  logic [31:0] alu_out_M;
  logic [31:0] dm_out_M;
  logic [1:0]  addr_low_M;
  logic        valid_W;
  logic [31:0] instr_W;
  logic [31:0] pc_W;
  logic        reg_write;
  logic [4:0]  reg_addr;
  logic [2:0]  reg_data_op;
  logic [2:0]  give_W_op;
  logic [31:0] wd_W;

  int total = 0;
  int bad   = 0;

  w_stage_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .flush       (flush),
    .instr_M     (instr_M),
    .pc_M        (pc_M),
    .alu_out_M   (alu_out_M),
    .dm_out_M    (dm_out_M),
    .addr_low_M  (addr_low_M),
    .valid_W     (valid_W),
    .instr_W     (instr_W),
    .pc_W        (pc_W),
    .reg_write   (reg_write),
    .reg_addr    (reg_addr),
    .reg_data_op (reg_data_op),
    .give_W_op   (give_W_op),
    .wd_W        (wd_W)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Drive M inputs, then wait one edge and settle past it
  task automatic step(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] alu,
                      input logic [31:0] dm, input logic [1:0] al, input logic e, input logic f);
    instr_M = ins; pc_M = pc; alu_out_M = alu; dm_out_M = dm; addr_low_M = al;
    en = e; flush = f;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; flush = 1'b0;
    instr_M = 32'h0; pc_M = 32'h0; alu_out_M = 32'h0; dm_out_M = 32'h0; addr_low_M = 2'd0;
    #2;
    chk("rst_valid", {31'd0, valid_W}, 32'd0);
    chk("rst_instr", instr_W, 32'h0);
    chk("rst_pc", pc_W, 32'h0);
    chk("rst_rw", {31'd0, reg_write}, 32'd0);
    chk("rst_addr", {27'd0, reg_addr}, 32'd0);
    chk("rst_sel", {29'd0, reg_data_op}, 32'd0);
    chk("rst_give", {29'd0, give_W_op}, 32'd7);
    chk("rst_wd", wd_W, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // add $3,$1,$2
    step(32'h00221820, 32'h00001000, 32'h00000005, 32'hAAAAAAAA, 2'd1, 1'b1, 1'b0);
    chk("add_valid", {31'd0, valid_W}, 32'd1);
    chk("add_rw", {31'd0, reg_write}, 32'd1);
    chk("add_addr", {27'd0, reg_addr}, 32'd3);
    chk("add_sel", {29'd0, reg_data_op}, 32'd0);
    chk("add_give", {29'd0, give_W_op}, 32'd0);
    chk("add_wd", wd_W, 32'h00000005);
    chk("add_pc", pc_W, 32'h00001000);

    // lb $4,2($0)
    step(32'h80040002, 32'h00001004, 32'h00000002, 32'h12F45678, 2'd2, 1'b1, 1'b0);
    chk("lb_wd", wd_W, 32'hFFFFFFF4);
    chk("lb_addr", {27'd0, reg_addr}, 32'd4);
    chk("lb_sel", {29'd0, reg_data_op}, 32'd1);
    chk("lb_give", {29'd0, give_W_op}, 32'd1);
    // lbu, same data
    step(32'h90040002, 32'h00001008, 32'h00000002, 32'h12F45678, 2'd2, 1'b1, 1'b0);
    chk("lbu_wd", wd_W, 32'h000000F4);
    // lh, addr_low 2
    step(32'h84040002, 32'h0000100C, 32'h00000002, 32'h12F45678, 2'd2, 1'b1, 1'b0);
    chk("lh_wd", wd_W, 32'h000012F4);
    // lb, addr_low 0 -> positive byte
    step(32'h80040000, 32'h00001010, 32'h00000000, 32'h12F45678, 2'd0, 1'b1, 1'b0);
    chk("lb0_wd", wd_W, 32'h00000078);
    // lh, addr_low 1 (bit 0 ignored) on negative low half
    step(32'h84040001, 32'h00001014, 32'h00000001, 32'h12348765, 2'd1, 1'b1, 1'b0);
    chk("lh1_wd", wd_W, 32'hFFFF8765);
    // lhu $7, addr_low 3 -> upper half zero-extended
    step(32'h94070003, 32'h00001018, 32'h00000003, 32'hBEEF0001, 2'd3, 1'b1, 1'b0);
    chk("lhu_wd", wd_W, 32'h0000BEEF);
    chk("lhu_addr", {27'd0, reg_addr}, 32'd7);
    // lw $6,0($0)
    step(32'h8C060000, 32'h0000101C, 32'h00000000, 32'hCAFEBABE, 2'd0, 1'b1, 1'b0);
    chk("lw_wd", wd_W, 32'hCAFEBABE);

    // jal
    step(32'h0C000C00, 32'h00003000, 32'h11111111, 32'h0, 2'd0, 1'b1, 1'b0);
    chk("jal_addr", {27'd0, reg_addr}, 32'd31);
    chk("jal_sel", {29'd0, reg_data_op}, 32'd2);
    chk("jal_give", {29'd0, give_W_op}, 32'd2);
    chk("jal_wd", wd_W, 32'h00003008);
    // jalr $5,$1
    step(32'h00202809, 32'h00004000, 32'h22222222, 32'h0, 2'd0, 1'b1, 1'b0);
    chk("jalr_addr", {27'd0, reg_addr}, 32'd5);
    chk("jalr_wd", wd_W, 32'h00004008);
    // jal at top of address space wraps
    step(32'h0C000000, 32'hFFFFFFFC, 32'h0, 32'h0, 2'd0, 1'b1, 1'b0);
    chk("jal_wrap_wd", wd_W, 32'h00000004);

    // ori $8,$0,imm -> alu path, rt
    step(32'h34080055, 32'h00005000, 32'h00000055, 32'h0, 2'd0, 1'b1, 1'b0);
    chk("ori_addr", {27'd0, reg_addr}, 32'd8);
    chk("ori_wd", wd_W, 32'h00000055);

    // add with rd = 0
    step(32'h00220020, 32'h00005004, 32'h00000009, 32'h0, 2'd0, 1'b1, 1'b0);
    chk("rd0_rw", {31'd0, reg_write}, 32'd0);
    chk("rd0_addr", {27'd0, reg_addr}, 32'd0);
    chk("rd0_give", {29'd0, give_W_op}, 32'd7);
    // sw
    step(32'hAC220000, 32'h00005008, 32'h00000100, 32'h0, 2'd0, 1'b1, 1'b0);
    chk("sw_rw", {31'd0, reg_write}, 32'd0);
    chk("sw_give", {29'd0, give_W_op}, 32'd7);
    chk("sw_valid", {31'd0, valid_W}, 32'd1);

    // Capture add, then stall three cycles with changing inputs
    step(32'h00221820, 32'h00006000, 32'h00000005, 32'h0, 2'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(32'h8C060000 + i, 32'h00007000 + i, 32'hDEAD0000 + i, 32'h12345678, 2'd3, 1'b0, 1'b0);
      chk("stall_instr", instr_W, 32'h00221820);
      chk("stall_wd", wd_W, 32'h00000005);
      chk("stall_addr", {27'd0, reg_addr}, 32'd3);
      chk("stall_pc", pc_W, 32'h00006000);
    end
    // Stall plus flush: bubble wins
    step(32'h8C060000, 32'h00007000, 32'hDEAD0000, 32'h0, 2'd0, 1'b0, 1'b1);
    chk("flush_valid", {31'd0, valid_W}, 32'd0);
    chk("flush_give", {29'd0, give_W_op}, 32'd7);
    chk("flush_rw", {31'd0, reg_write}, 32'd0);
    // Flush also beats en=1
    step(32'h00221820, 32'h00006000, 32'h00000005, 32'h0, 2'd0, 1'b1, 1'b0);
    step(32'h00221820, 32'h00006000, 32'h00000005, 32'h0, 2'd0, 1'b1, 1'b1);
    chk("flush_en_valid", {31'd0, valid_W}, 32'd0);
    chk("flush_en_instr", instr_W, 32'h0);

    // Capture lw, then asynchronous reset between edges
    step(32'h8C060000, 32'h00008000, 32'h0, 32'h0BADF00D, 2'd0, 1'b1, 1'b0);
    chk("lw2_wd", wd_W, 32'h0BADF00D);
    en = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    chk("arst_valid", {31'd0, valid_W}, 32'd0);
    chk("arst_wd", wd_W, 32'h0);
    chk("arst_give", {29'd0, give_W_op}, 32'd7);
    #1;
    reset = 1'b0;
    // Next captured instruction appears normally
    step(32'h00221820, 32'h00009000, 32'h00000077, 32'h0, 2'd0, 1'b1, 1'b0);
    chk("post_valid", {31'd0, valid_W}, 32'd1);
    chk("post_addr", {27'd0, reg_addr}, 32'd3);
    chk("post_wd", wd_W, 32'h00000077);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
